// File: rtl/mac_lane_pkg.sv
// Shared constants and per-lane configuration layout for the MAC lane tile.
// A lane config nibble is {SIGNED, SAT, MODE[1:0]}.
package mac_lane_pkg;
  localparam int LANE_CONF_W = 4;
  localparam int SIGNED_BIT  = 3;
  localparam int SAT_BIT     = 2;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_MUL  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_RSVD = 2'b11
  } lane_mode_e;

  typedef struct packed {
    logic       is_signed;
    logic       sat;
    lane_mode_e mode;
  } lane_cfg_t;

  function automatic lane_cfg_t decode_cfg(input logic [LANE_CONF_W-1:0] bits);
    lane_cfg_t c;
    c.is_signed = bits[SIGNED_BIT];
    c.sat       = bits[SAT_BIT];
    c.mode      = lane_mode_e'(bits[1:0]);
    return c;
  endfunction
endpackage

// File: rtl/mac_lane.sv
// One MAC lane: stage-1 multiply, stage-2 pass-through or accumulate
// with optional signed/unsigned saturation.
module mac_lane
  import mac_lane_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  lane_cfg_t        cfg,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             acc_clr,
  input  logic             v1,
  output logic [ACC_W-1:0] out
);
  localparam int P_W = 2 * IN_W;
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] S_MAX = ~S_MIN;

  logic [P_W-1:0]        p_q, p_d;
  logic                  clr1_q, clr1_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      out_q, out_d;

  logic signed [IN_W:0]  a_ext, b_ext;
  logic signed [P_W+1:0] prod;
  logic [ACC_W-1:0]      x, base, res;
  logic [ACC_W:0]        sum;

  // One extra operand bit lets a single signed multiplier cover both signednesses.
  always_comb begin
    a_ext  = {cfg.is_signed & a[IN_W-1], a};
    b_ext  = {cfg.is_signed & b[IN_W-1], b};
    prod   = (P_W+2)'(a_ext) * (P_W+2)'(b_ext);
    p_d    = en ? prod[P_W-1:0] : p_q;
    clr1_d = en ? acc_clr : clr1_q;
  end

  // The sum is one bit wider than the accumulator so overflow is visible in the top bits.
  always_comb begin
    x    = cfg.is_signed ? ACC_W'($signed(p_q)) : ACC_W'(p_q);
    base = clr1_q ? '0 : acc_q;
    sum  = {cfg.is_signed & base[ACC_W-1], base} + {cfg.is_signed & x[ACC_W-1], x};
    res  = sum[ACC_W-1:0];
    if (cfg.sat) begin
      if (cfg.is_signed) begin
        if (sum[ACC_W] != sum[ACC_W-1]) res = sum[ACC_W] ? S_MIN : S_MAX;
      end else if (sum[ACC_W]) begin
        res = '1;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    if (en) begin
      case (cfg.mode)
        MODE_MUL: begin
          if (v1) out_d = x;
        end
        MODE_ACC: begin
          if (v1)          acc_d = res;
          else if (clr1_q) acc_d = '0;
          out_d = acc_d;
        end
        default: begin
          acc_d = '0;
          out_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q    <= '0;
      clr1_q <= 1'b0;
      acc_q  <= '0;
      out_q  <= '0;
    end else begin
      p_q    <= p_d;
      clr1_q <= clr1_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;
endmodule

// File: rtl/mac_lane_tile.sv
// LANES-wide MAC tile: serial config shadow chain, active config latch,
// shared valid pipeline and one mac_lane per lane.
module mac_lane_tile
  import mac_lane_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cen,
  input  logic                   cset,
  input  logic                   shift_in,
  output logic                   shift_out,
  output logic                   cset_out,
  input  logic                   in_valid,
  input  logic [LANES*IN_W-1:0]  a,
  input  logic [LANES*IN_W-1:0]  b,
  input  logic [LANES-1:0]       acc_clr,
  output logic                   out_valid,
  output logic [LANES*ACC_W-1:0] out
);
  localparam int CONF_W = LANES * LANE_CONF_W;

  logic [CONF_W-1:0] shadow_q, shadow_d;
  logic [CONF_W-1:0] active_q, active_d;
  logic              cset_out_q, cset_out_d;
  logic              v1_q, v1_d;
  logic              out_valid_q, out_valid_d;

  // The config chain runs independently of en; cset captures the pre-shift shadow.
  always_comb begin
    shadow_d    = cen ? {shadow_q[CONF_W-2:0], shift_in} : shadow_q;
    active_d    = cset ? shadow_q : active_q;
    cset_out_d  = cset;
    v1_d        = en ? in_valid : v1_q;
    out_valid_d = en ? v1_q : out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q    <= '0;
      active_q    <= '0;
      cset_out_q  <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cset_out_q  <= cset_out_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cfg     (decode_cfg(active_q[i*LANE_CONF_W +: LANE_CONF_W])),
      .a       (a[i*IN_W +: IN_W]),
      .b       (b[i*IN_W +: IN_W]),
      .acc_clr (acc_clr[i]),
      .v1      (v1_q),
      .out     (out[i*ACC_W +: ACC_W])
    );
  end

  assign shift_out = shadow_q[CONF_W-1];
  assign cset_out  = cset_out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mac_lane_tile.sv
// Directed + random bench for mac_lane_tile against an arithmetic reference model;
// a 16-bit-accumulator single-lane tile shares lane-0 stimulus to reach saturation.
module tb_mac_lane_tile;
  localparam int LANES = 4;
  localparam int IN_W  = 8;
  localparam int ACC_W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, cen = 1'b0, cset = 1'b0;
  logic shift_in = 1'b0, in_valid = 1'b0;
  logic [LANES*IN_W-1:0]  a = '0, b = '0;
  logic [LANES-1:0]       acc_clr = '0;
  logic                   shift_out, cset_out, out_valid;
  logic [LANES*ACC_W-1:0] out;
  logic                   shift_out2, cset_out2, out_valid2;
  logic [15:0]            out2;

  int n_assert = 0, n_fail = 0;

  bit [15:0] m_shadow, m_active;
  bit        m_cso, m_v1, m_ov;
  bit [15:0] m_p   [LANES];
  bit        m_clr [LANES];
  bit [31:0] m_acc [LANES];
  bit [31:0] m_out [LANES];

  always #5 clk = ~clk;

  mac_lane_tile #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cen(cen), .cset(cset), .shift_in(shift_in),
    .shift_out(shift_out), .cset_out(cset_out), .in_valid(in_valid), .a(a), .b(b),
    .acc_clr(acc_clr), .out_valid(out_valid), .out(out));

  mac_lane_tile #(.LANES(1), .IN_W(IN_W), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .cen(cen), .cset(cset), .shift_in(shift_in),
    .shift_out(shift_out2), .cset_out(cset_out2), .in_valid(in_valid), .a(a[7:0]),
    .b(b[7:0]), .acc_clr(acc_clr[0:0]), .out_valid(out_valid2), .out(out2));

  function automatic bit [15:0] mul16(input bit [3:0] c, input bit [7:0] x, input bit [7:0] y);
    int pr;
    if (c[3]) pr = int'($signed(x)) * int'($signed(y));
    else      pr = int'(x) * int'(y);
    return pr[15:0];
  endfunction

  function automatic void lane2(input bit [3:0] c, input bit [15:0] p, input bit clr, input bit v,
                                input bit [31:0] acc_i, input bit [31:0] out_i,
                                output bit [31:0] acc_o, output bit [31:0] out_o);
    longint x, base, s;
    acc_o = acc_i;
    out_o = out_i;
    x = c[3] ? longint'($signed(p)) : longint'(p);
    case (c[1:0])
      2'b01: if (v) out_o = x[31:0];
      2'b10: begin
        base = clr ? 64'sd0 : (c[3] ? longint'($signed(acc_i)) : longint'(acc_i));
        if (v) begin
          s = base + x;
          if (c[2]) begin
            if (c[3]) begin
              if (s > SMAX) s = SMAX;
              if (s < SMIN) s = SMIN;
            end else if (s > UMAX) s = UMAX;
          end
          acc_o = s[31:0];
        end else if (clr) acc_o = '0;
        out_o = acc_o;
      end
      default: begin
        acc_o = '0;
        out_o = '0;
      end
    endcase
  endfunction

  task automatic model_update();
    if (!rst) begin
      m_shadow = '0; m_active = '0; m_cso = 0; m_v1 = 0; m_ov = 0;
      for (int l = 0; l < LANES; l++) begin
        m_p[l] = '0; m_clr[l] = 0; m_acc[l] = '0; m_out[l] = '0;
      end
    end else begin
      if (en) begin
        for (int l = 0; l < LANES; l++)
          lane2(m_active[4*l +: 4], m_p[l], m_clr[l], m_v1, m_acc[l], m_out[l], m_acc[l], m_out[l]);
        m_ov = m_v1;
        m_v1 = in_valid;
        for (int l = 0; l < LANES; l++) begin
          m_p[l]   = mul16(m_active[4*l +: 4], a[8*l +: 8], b[8*l +: 8]);
          m_clr[l] = acc_clr[l];
        end
      end
      m_cso = cset;
      if (cset) m_active = m_shadow;
      if (cen)  m_shadow = {m_shadow[14:0], shift_in};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("cset_out", 32'(cset_out), 32'(m_cso));
    chk("shift_out", 32'(shift_out), 32'(m_shadow[15]));
    chk("cset_out16", 32'(cset_out2), 32'(m_cso));
    chk("out_valid16", 32'(out_valid2), 32'(m_ov));
    chk("shift_out16", 32'(shift_out2), 32'(m_shadow[3]));
    for (int l = 0; l < LANES; l++)
      chk($sformatf("out[%0d]", l), out[l*32 +: 32], m_out[l]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic load_cfg(input bit [15:0] w);
    rst = 1; en = 1; in_valid = 0; acc_clr = '0; cset = 0; cen = 1;
    for (int k = 15; k >= 0; k--) begin
      shift_in = w[k];
      tick();
    end
    cen = 0; cset = 1;
    tick();
    cset = 0;
  endtask

  task automatic set_op(input bit v, input bit clr0, input bit [7:0] a0, input bit [7:0] b0);
    rst = 1; en = 1; cen = 0; cset = 0;
    a = $urandom; b = $urandom;
    a[7:0] = a0; b[7:0] = b0;
    in_valid = v;
    acc_clr = 4'($urandom);
    acc_clr[0] = clr0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [15:0] w1, w2, w;

    // Reset with random inputs
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'($urandom); en = 1'($urandom);
      cen = 1'($urandom); cset = 1'($urandom); shift_in = 1'($urandom); acc_clr = 4'($urandom);
      tick();
    end
    chk("rst_out_any", 32'(|out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_shift_out", 32'(shift_out), 32'd0);
    chk("rst_cset_out", 32'(cset_out), 32'd0);
    set_op(0, 0, 0, 0);
    tick();

    // Config chain: load, observe cset_out, then shift the word back out
    w1 = 16'($urandom);
    w2 = 16'($urandom);
    load_cfg(w1);
    chk("cset_out_after_cset", 32'(cset_out), 32'd1);
    cen = 1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("chain_bit%0d", k), 32'(shift_out), 32'(w1[15-k]));
      shift_in = w2[15-k];
      tick();
      if (k == 0) chk("cset_out_drop", 32'(cset_out), 32'd0);
    end
    cen = 0;

    // MUL signed / unsigned
    w = 16'($urandom); w[3:0] = 4'b1001; load_cfg(w);
    set_op(1, 0, 8'hFF, 8'h02); tick();
    set_op(0, 0, 8'h00, 8'h00); tick();
    chk("mul_signed", out[31:0], 32'hFFFF_FFFE);
    w = 16'($urandom); w[3:0] = 4'b0001; load_cfg(w);
    set_op(1, 0, 8'hFF, 8'h02); tick();
    set_op(0, 0, 8'h00, 8'h00); tick();
    chk("mul_unsigned", out[31:0], 32'h0000_01FE);

    // ACC wrap vs saturate from a preload of 0xFFFFFF00
    for (int s = 0; s < 2; s++) begin
      w = 16'($urandom); w[3:0] = 4'b1010; load_cfg(w);
      set_op(1, 1, 8'h80, 8'h02); tick();
      w = 16'($urandom); w[3:0] = (s == 0) ? 4'b0010 : 4'b0110; load_cfg(w);
      chk("acc_preload", out[31:0], 32'hFFFF_FF00);
      set_op(1, 0, 8'hFF, 8'hFF); tick();
      set_op(0, 0, 8'h00, 8'h00); tick();
      chk(s == 0 ? "acc_wrap" : "acc_usat", out[31:0], (s == 0) ? 32'h0000_FD01 : 32'hFFFF_FFFF);
    end

    // Signed saturation at both rails on the 16-bit accumulator tile
    w = 16'($urandom); w[3:0] = 4'b1110; load_cfg(w);
    set_op(1, 1, 8'h7F, 8'h7F); tick();
    set_op(1, 0, 8'h7F, 8'h7F); tick(); chk("ssat16_a", 32'(out2), 32'h3F01);
    set_op(1, 0, 8'h7F, 8'h7F); tick(); chk("ssat16_b", 32'(out2), 32'h7E02);
    set_op(1, 1, 8'h80, 8'h7F); tick(); chk("ssat16_max", 32'(out2), 32'h7FFF);
    set_op(1, 0, 8'h80, 8'h7F); tick(); chk("ssat16_c", 32'(out2), 32'hC080);
    set_op(1, 0, 8'h80, 8'h7F); tick(); chk("ssat16_d", 32'(out2), 32'h8100);
    set_op(0, 0, 8'h00, 8'h00); tick(); chk("ssat16_min", 32'(out2), 32'h8000);

    // Clear behaviour
    w = 16'($urandom); w[3:0] = 4'b0010; load_cfg(w);
    set_op(1, 1, 8'd3, 8'd4); tick();
    set_op(1, 0, 8'd5, 8'd6); tick(); chk("clr_12", out[31:0], 32'd12);
    set_op(1, 1, 8'd2, 8'd2); tick(); chk("clr_42", out[31:0], 32'd42);
    set_op(0, 1, 8'd0, 8'd0); tick(); chk("clr_4", out[31:0], 32'd4);
    set_op(0, 0, 8'd0, 8'd0); tick();
    chk("clr_only_acc", out[31:0], 32'd0);
    chk("clr_only_valid", 32'(out_valid), 32'd0);

    // cen and cset together: active takes the pre-shift shadow
    w = 16'($urandom); w[3:0] = 4'b0001; load_cfg(w);
    cen = 1; cset = 1; shift_in = 1; tick();
    set_op(1, 0, 8'd3, 8'd5); tick();
    set_op(0, 0, 8'd0, 8'd0); tick();
    chk("cen_cset_pre_shift", out[31:0], 32'd15);

    // Stall mid-stream
    load_cfg({4'b0001, 4'b1110, 4'b0110, 4'b1010});
    for (int i = 0; i < 12; i++) begin
      set_op(1, 1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom));
      en = !(i >= 4 && i < 7);
      tick();
    end
    set_op(0, 0, 8'd0, 8'd0); tick(); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        load_cfg(16'($urandom));
      end else begin
        rst = ($urandom_range(0, 99) != 0);
        en  = ($urandom_range(0, 7) != 0);
        cen = ($urandom_range(0, 3) == 0);
        cset = ($urandom_range(0, 15) == 0);
        shift_in = 1'($urandom);
        a = $urandom; b = $urandom; in_valid = 1'($urandom);
        for (int l = 0; l < LANES; l++) acc_clr[l] = ($urandom_range(0, 7) == 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
